// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame receiver.
package uart_pkg;

  localparam int unsigned FRAME_W = 9;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  // Returns 1 when data plus received parity bit does not match the expected sense.
  function automatic logic parity_fail(input logic [DATA_W-1:0] d, input logic p, input logic odd);
    return (^{d, p}) != odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks, held in phase by clr.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= '0;
    else if (clr || cnt == LAST)  cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_frame_receiver.sv
// UART receiver: 8 data + parity + stop, LSB first; emits {parity, data} with strobes.
module uart_frame_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_valid,
  output logic               parity_err,
  output logic               frame_err,
  output logic               busy
);

  localparam int unsigned   DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned   DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned   TW      = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_T   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_T  = TW'(OVERSAMPLE - 1);

  state_t              state, state_d;
  logic                rx_meta, rx_s, rx_prev;
  logic                tick;
  logic [TW-1:0]       tick_cnt, tick_cnt_d;
  logic [2:0]          bit_cnt, bit_cnt_d;
  logic [DATA_W-1:0]   shift, shift_d;
  logic                par, par_d;
  logic [FRAME_W-1:0]  frame_d;
  logic                fv_d, pe_d, fe_d;
  logic                mid_tick, bit_tick;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .tick (tick)
  );

  assign mid_tick = tick && (tick_cnt == MID_T);
  assign bit_tick = tick && (tick_cnt == LAST_T);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      par         <= 1'b0;
      frame       <= '0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_s        <= rx_meta;
      rx_prev     <= rx_s;
      state       <= state_d;
      tick_cnt    <= tick_cnt_d;
      bit_cnt     <= bit_cnt_d;
      shift       <= shift_d;
      par         <= par_d;
      frame       <= frame_d;
      frame_valid <= fv_d;
      parity_err  <= pe_d;
      frame_err   <= fe_d;
    end
  end

  always_comb begin
    state_d    = state;
    tick_cnt_d = tick_cnt;
    bit_cnt_d  = bit_cnt;
    shift_d    = shift;
    par_d      = par;
    frame_d    = frame;
    fv_d       = 1'b0;
    pe_d       = 1'b0;
    fe_d       = 1'b0;

    if (tick) tick_cnt_d = (tick_cnt == LAST_T) ? '0 : tick_cnt + 1'b1;

    case (state)
      IDLE: begin
        tick_cnt_d = '0;
        if (rx_prev && !rx_s) begin
          state_d   = START;
          bit_cnt_d = '0;
        end
      end
      START: begin
        // Restarting the tick count here puts every later sample at mid-bit.
        if (mid_tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d    = DATA;
            tick_cnt_d = '0;
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d[bit_cnt] = rx_s;
          bit_cnt_d        = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          par_d   = rx_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (rx_s) begin
            frame_d = {par, shift};
            fv_d    = 1'b1;
            pe_d    = parity_fail(shift, par, PARITY_ODD);
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
